// File: rtl/vtx_trace_gen.sv
// Retire-trace generator: snapshots CPRs around one coprocessor instruction,
// records up to four memory transactions, and emits a single trace pulse.
module vtx_trace_gen (
  input  logic         vtx_clk,
  input  logic         vtx_reset,
  input  logic         cop_insn_valid,
  output logic         cop_insn_ready,
  input  logic [31:0]  cop_insn_enc,
  input  logic [31:0]  cop_rs1,
  input  logic         cpr_wen,
  input  logic [3:0]   cpr_waddr,
  input  logic [31:0]  cpr_wdata,
  input  logic         mem_cen,
  input  logic         mem_wen,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_ben,
  input  logic         mem_gnt,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_error,
  input  logic         cop_rsp_valid,
  input  logic         cop_rsp_ack,
  input  logic [2:0]   cop_rsp_result,
  input  logic [31:0]  cop_rsp_wdata,
  input  logic [4:0]   cop_rsp_waddr,
  input  logic         cop_rsp_wen,
  output logic         vtx_valid,
  output logic [31:0]  vtx_instr_enc,
  output logic [31:0]  vtx_instr_rs1,
  output logic [31:0]  vtx_instr_wdata,
  output logic [2:0]   vtx_instr_result,
  output logic [4:0]   vtx_instr_waddr,
  output logic         vtx_instr_wen,
  output logic [3:0]   vtx_mem_cen,
  output logic [3:0]   vtx_mem_wen,
  output logic [3:0]   vtx_mem_error,
  output logic [127:0] vtx_mem_addr,
  output logic [127:0] vtx_mem_wdata,
  output logic [127:0] vtx_mem_rdata,
  output logic [15:0]  vtx_mem_ben,
  output logic         vtx_mem_ovf,
  output logic [511:0] vtx_cprs_pre,
  output logic [511:0] vtx_cprs_post
);

  // Handshakes: issue accepted when cop_insn_valid && cop_insn_ready; memory
  // request accepted when mem_cen && mem_gnt (rdata/error valid next cycle);
  // completion accepted when cop_rsp_valid && cop_rsp_ack while BUSY.
  typedef enum logic [1:0] {IDLE, BUSY, EMIT} state_t;

  state_t       state_q, state_d;
  logic [511:0] shadow_q, shadow_eff;
  logic [2:0]   slot_cnt_q;
  logic [1:0]   rd_slot_q;
  logic         rd_pend_q;
  logic         rsp_done_q;
  logic         issue_acc, rsp_acc, req_busy, req_rec;

  // Shadow view including a CPR write landing in the current cycle.
  always_comb begin
    shadow_eff = shadow_q;
    if (cpr_wen) shadow_eff[{cpr_waddr, 5'd0} +: 32] = cpr_wdata;
  end

  assign req_busy = (state_q == BUSY) && mem_cen && mem_gnt;
  assign req_rec  = req_busy && (slot_cnt_q < 3'd4);

  always_comb begin
    state_d        = state_q;
    issue_acc      = 1'b0;
    rsp_acc        = 1'b0;
    cop_insn_ready = 1'b0;
    vtx_valid      = 1'b0;
    case (state_q)
      IDLE: begin
        cop_insn_ready = 1'b1;
        if (cop_insn_valid) begin
          issue_acc = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        rsp_acc = cop_rsp_valid && cop_rsp_ack && !rsp_done_q;
        // A request recorded this cycle still owes rdata; hold BUSY for it.
        if ((rsp_acc || rsp_done_q) && !req_rec) state_d = EMIT;
      end
      EMIT: begin
        vtx_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      state_q          <= IDLE;
      shadow_q         <= '0;
      slot_cnt_q       <= '0;
      rd_slot_q        <= '0;
      rd_pend_q        <= 1'b0;
      rsp_done_q       <= 1'b0;
      vtx_instr_enc    <= '0;
      vtx_instr_rs1    <= '0;
      vtx_instr_wdata  <= '0;
      vtx_instr_result <= '0;
      vtx_instr_waddr  <= '0;
      vtx_instr_wen    <= 1'b0;
      vtx_mem_cen      <= '0;
      vtx_mem_wen      <= '0;
      vtx_mem_error    <= '0;
      vtx_mem_addr     <= '0;
      vtx_mem_wdata    <= '0;
      vtx_mem_rdata    <= '0;
      vtx_mem_ben      <= '0;
      vtx_mem_ovf      <= 1'b0;
      vtx_cprs_pre     <= '0;
      vtx_cprs_post    <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_eff;
      rd_pend_q <= req_rec;

      if (issue_acc) begin
        vtx_instr_enc <= cop_insn_enc;
        vtx_instr_rs1 <= cop_rs1;
        vtx_cprs_pre  <= shadow_eff;
        vtx_mem_cen   <= '0;
        vtx_mem_wen   <= '0;
        vtx_mem_error <= '0;
        vtx_mem_addr  <= '0;
        vtx_mem_wdata <= '0;
        vtx_mem_rdata <= '0;
        vtx_mem_ben   <= '0;
        vtx_mem_ovf   <= 1'b0;
        slot_cnt_q    <= '0;
        rsp_done_q    <= 1'b0;
      end

      if (req_rec) begin
        vtx_mem_cen[slot_cnt_q[1:0]]                    <= 1'b1;
        vtx_mem_wen[slot_cnt_q[1:0]]                    <= mem_wen;
        vtx_mem_addr[{slot_cnt_q[1:0], 5'd0} +: 32]     <= mem_addr;
        vtx_mem_wdata[{slot_cnt_q[1:0], 5'd0} +: 32]    <= mem_wdata;
        vtx_mem_ben[{slot_cnt_q[1:0], 2'd0} +: 4]       <= mem_ben;
        rd_slot_q                                       <= slot_cnt_q[1:0];
        slot_cnt_q                                      <= slot_cnt_q + 3'd1;
      end else if (req_busy) begin
        vtx_mem_ovf <= 1'b1;
      end

      if (rd_pend_q) begin
        vtx_mem_rdata[{rd_slot_q, 5'd0} +: 32] <= mem_rdata;
        vtx_mem_error[rd_slot_q]               <= mem_error;
      end

      if (rsp_acc) begin
        vtx_instr_result <= cop_rsp_result;
        vtx_instr_wdata  <= cop_rsp_wdata;
        vtx_instr_waddr  <= cop_rsp_waddr;
        vtx_instr_wen    <= cop_rsp_wen;
        vtx_cprs_post    <= shadow_eff;
        rsp_done_q       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vtx_trace_gen.sv
// Directed bench for vtx_trace_gen: one task per scenario with inline checks
// against hand-computed values.
module tb_vtx_trace_gen;

  logic         vtx_clk = 1'b0;
  logic         vtx_reset;
  logic         cop_insn_valid, cop_insn_ready;
  logic [31:0]  cop_insn_enc, cop_rs1;
  logic         cpr_wen;
  logic [3:0]   cpr_waddr;
  logic [31:0]  cpr_wdata;
  logic         mem_cen, mem_wen, mem_gnt, mem_error;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_ben;
  logic         cop_rsp_valid, cop_rsp_ack, cop_rsp_wen;
  logic [2:0]   cop_rsp_result;
  logic [31:0]  cop_rsp_wdata;
  logic [4:0]   cop_rsp_waddr;
  logic         vtx_valid;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
  logic [2:0]   vtx_instr_result;
  logic [4:0]   vtx_instr_waddr;
  logic         vtx_instr_wen;
  logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
  logic [15:0]  vtx_mem_ben;
  logic         vtx_mem_ovf;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;

  int n_cmp = 0;
  int n_fail = 0;

  vtx_trace_gen dut (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .cop_insn_valid(cop_insn_valid), .cop_insn_ready(cop_insn_ready),
    .cop_insn_enc(cop_insn_enc), .cop_rs1(cop_rs1),
    .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wdata(cpr_wdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ben(mem_ben), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ack(cop_rsp_ack),
    .cop_rsp_result(cop_rsp_result), .cop_rsp_wdata(cop_rsp_wdata),
    .cop_rsp_waddr(cop_rsp_waddr), .cop_rsp_wen(cop_rsp_wen),
    .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
    .vtx_instr_wdata(vtx_instr_wdata), .vtx_instr_result(vtx_instr_result),
    .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wen(vtx_instr_wen),
    .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
    .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata),
    .vtx_mem_ben(vtx_mem_ben), .vtx_mem_ovf(vtx_mem_ovf),
    .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post)
  );

  // Clock / reset block
  always #5 vtx_clk = ~vtx_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge vtx_clk);
    #1;
  endtask

  task automatic idle_inputs();
    vtx_reset = 1'b0; cop_insn_valid = 1'b0; cop_insn_enc = '0; cop_rs1 = '0;
    cpr_wen = 1'b0; cpr_waddr = '0; cpr_wdata = '0;
    mem_cen = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_ben = '0;
    mem_gnt = 1'b0; mem_rdata = '0; mem_error = 1'b0;
    cop_rsp_valid = 1'b0; cop_rsp_ack = 1'b0; cop_rsp_result = '0;
    cop_rsp_wdata = '0; cop_rsp_waddr = '0; cop_rsp_wen = 1'b0;
  endtask

  // Driver tasks
  task automatic drive_issue(input logic [31:0] enc, input logic [31:0] rs1);
    cop_insn_valid = 1'b1; cop_insn_enc = enc; cop_rs1 = rs1;
    step();
    cop_insn_valid = 1'b0;
  endtask

  task automatic set_rsp(input logic [2:0] res, input logic [31:0] wd,
                         input logic [4:0] wa, input logic we);
    cop_rsp_valid = 1'b1; cop_rsp_ack = 1'b1; cop_rsp_result = res;
    cop_rsp_wdata = wd; cop_rsp_waddr = wa; cop_rsp_wen = we;
  endtask

  task automatic clr_rsp();
    cop_rsp_valid = 1'b0; cop_rsp_ack = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic g);
    mem_cen = 1'b1; mem_wen = we; mem_addr = a; mem_wdata = wd; mem_ben = be; mem_gnt = g;
  endtask

  task automatic test_reset();
    idle_inputs();
    vtx_reset = 1'b1;
    step(); step();
    vtx_reset = 1'b0;
    n_cmp++; if (cop_insn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", cop_insn_ready); end
    n_cmp++; if (vtx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", vtx_valid); end
    n_cmp++; if (vtx_instr_enc !== 32'h0) begin n_fail++; $display("FAIL reset_enc: got %h exp 0", vtx_instr_enc); end
    n_cmp++; if (vtx_cprs_pre !== 512'h0 || vtx_cprs_post !== 512'h0) begin n_fail++; $display("FAIL reset_cprs: pre/post not zero"); end
    n_cmp++; if (vtx_mem_cen !== 4'h0 || vtx_mem_addr !== 128'h0 || vtx_mem_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_mem: cen %h ovf %0b exp 0 0", vtx_mem_cen, vtx_mem_ovf); end
  endtask

  task automatic test_basic();
    cpr_wen = 1'b1; cpr_waddr = 4'd3; cpr_wdata = 32'hDEADBEEF;
    step();
    cpr_wen = 1'b0;
    drive_issue(32'h0000002B, 32'h00000011);
    n_cmp++; if (cop_insn_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_busy: got %0b exp 0", cop_insn_ready); end
    step();
    set_rsp(3'd1, 32'd7, 5'd5, 1'b1);
    n_cmp++; if (vtx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b exp 0", vtx_valid); end
    step();
    clr_rsp();
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_cprs_pre[3*32 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_pre_c3: got %h exp deadbeef", vtx_cprs_pre[3*32 +: 32]); end
    n_cmp++; if (vtx_instr_wdata !== 32'd7 || vtx_instr_waddr !== 5'd5 || vtx_instr_wen !== 1'b1 || vtx_instr_result !== 3'd1) begin n_fail++; $display("FAIL basic_rsp: wdata %h waddr %0d wen %0b res %0d exp 7 5 1 1", vtx_instr_wdata, vtx_instr_waddr, vtx_instr_wen, vtx_instr_result); end
    n_cmp++; if (vtx_instr_enc !== 32'h2B || vtx_instr_rs1 !== 32'h11) begin n_fail++; $display("FAIL basic_enc: enc %h rs1 %h exp 2b 11", vtx_instr_enc, vtx_instr_rs1); end
    n_cmp++; if (vtx_mem_cen !== 4'h0) begin n_fail++; $display("FAIL basic_mem_cen: got %h exp 0", vtx_mem_cen); end
    step();
    n_cmp++; if (vtx_valid !== 1'b0 || cop_insn_ready !== 1'b1) begin n_fail++; $display("FAIL basic_pulse_end: valid %0b ready %0b exp 0 1", vtx_valid, cop_insn_ready); end
    n_cmp++; if (vtx_instr_wdata !== 32'd7) begin n_fail++; $display("FAIL basic_hold: got %h exp 7", vtx_instr_wdata); end
  endtask

  task automatic test_busy_cpr_write();
    drive_issue(32'h00000033, 32'h0);
    cpr_wen = 1'b1; cpr_waddr = 4'd1; cpr_wdata = 32'h12345678;
    step();
    cpr_wen = 1'b0;
    set_rsp(3'd0, 32'h0, 5'd0, 1'b0);
    step();
    clr_rsp();
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL cpr_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_cprs_pre[1*32 +: 32] !== 32'h0) begin n_fail++; $display("FAIL cpr_pre_c1: got %h exp 0", vtx_cprs_pre[1*32 +: 32]); end
    n_cmp++; if (vtx_cprs_post[1*32 +: 32] !== 32'h12345678) begin n_fail++; $display("FAIL cpr_post_c1: got %h exp 12345678", vtx_cprs_post[1*32 +: 32]); end
    n_cmp++; if (vtx_cprs_post[3*32 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpr_post_c3: got %h exp deadbeef", vtx_cprs_post[3*32 +: 32]); end
    step();
  endtask

  task automatic test_two_loads();
    drive_issue(32'h00000003, 32'h100);
    set_req(1'b0, 32'h0F0, 32'h0, 4'hF, 1'b0);
    step();
    set_req(1'b0, 32'h100, 32'h0, 4'hF, 1'b1);
    step();
    set_req(1'b0, 32'h104, 32'h0, 4'hF, 1'b1);
    mem_rdata = 32'hAA; mem_error = 1'b0;
    step();
    mem_cen = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hBB; mem_error = 1'b1;
    step();
    mem_rdata = 32'h0; mem_error = 1'b0;
    set_rsp(3'd2, 32'h55, 5'd9, 1'b1);
    step();
    clr_rsp();
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_mem_cen !== 4'b0011 || vtx_mem_wen !== 4'b0000) begin n_fail++; $display("FAIL load_cen: cen %b wen %b exp 0011 0000", vtx_mem_cen, vtx_mem_wen); end
    n_cmp++; if (vtx_mem_addr[63:0] !== 64'h00000104_00000100) begin n_fail++; $display("FAIL load_addr: got %h exp 0000010400000100", vtx_mem_addr[63:0]); end
    n_cmp++; if (vtx_mem_rdata !== {64'h0, 32'hBB, 32'hAA}) begin n_fail++; $display("FAIL load_rdata: got %h exp bb/aa", vtx_mem_rdata); end
    n_cmp++; if (vtx_mem_error !== 4'b0010 || vtx_mem_ben !== 16'h00FF) begin n_fail++; $display("FAIL load_err_ben: err %b ben %h exp 0010 00ff", vtx_mem_error, vtx_mem_ben); end
    n_cmp++; if (vtx_mem_ovf !== 1'b0) begin n_fail++; $display("FAIL load_ovf: got %0b exp 0", vtx_mem_ovf); end
    step();
  endtask

  task automatic test_overflow();
    cpr_wen = 1'b1; cpr_waddr = 4'd2; cpr_wdata = 32'hCAFE0002;
    drive_issue(32'h00000023, 32'h200);
    cpr_wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 4'h3, 1'b1);
      step();
    end
    mem_cen = 1'b0; mem_gnt = 1'b0;
    set_rsp(3'd0, 32'h0, 5'd0, 1'b0);
    step();
    clr_rsp();
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_mem_cen !== 4'b1111 || vtx_mem_wen !== 4'b1111) begin n_fail++; $display("FAIL ovf_cen: cen %b wen %b exp 1111 1111", vtx_mem_cen, vtx_mem_wen); end
    n_cmp++; if (vtx_mem_addr[127:96] !== 32'h20C || vtx_mem_wdata[127:96] !== 32'h1003) begin n_fail++; $display("FAIL ovf_slot3: addr %h wdata %h exp 20c 1003", vtx_mem_addr[127:96], vtx_mem_wdata[127:96]); end
    n_cmp++; if (vtx_mem_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b exp 1", vtx_mem_ovf); end
    n_cmp++; if (vtx_mem_ben !== 16'h3333) begin n_fail++; $display("FAIL ovf_ben: got %h exp 3333", vtx_mem_ben); end
    n_cmp++; if (vtx_cprs_pre[2*32 +: 32] !== 32'hCAFE0002) begin n_fail++; $display("FAIL ovf_pre_same_cycle: got %h exp cafe0002", vtx_cprs_pre[2*32 +: 32]); end
    step();
  endtask

  task automatic test_late_request();
    drive_issue(32'h0000005B, 32'h300);
    step();
    set_req(1'b0, 32'h300, 32'h0, 4'h1, 1'b1);
    set_rsp(3'd5, 32'h99, 5'd17, 1'b1);
    step();
    mem_cen = 1'b0; mem_gnt = 1'b0; clr_rsp();
    mem_rdata = 32'h77;
    n_cmp++; if (vtx_valid !== 1'b0) begin n_fail++; $display("FAIL late_delay: got %0b exp 0", vtx_valid); end
    step();
    mem_rdata = 32'h0;
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL late_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_mem_rdata[31:0] !== 32'h77 || vtx_mem_cen !== 4'b0001) begin n_fail++; $display("FAIL late_rdata: rdata %h cen %b exp 77 0001", vtx_mem_rdata[31:0], vtx_mem_cen); end
    n_cmp++; if (vtx_mem_ovf !== 1'b0) begin n_fail++; $display("FAIL late_ovf_cleared: got %0b exp 0", vtx_mem_ovf); end
    n_cmp++; if (vtx_instr_wdata !== 32'h99 || vtx_instr_result !== 3'd5 || vtx_instr_waddr !== 5'd17) begin n_fail++; $display("FAIL late_rsp: wdata %h res %0d waddr %0d exp 99 5 17", vtx_instr_wdata, vtx_instr_result, vtx_instr_waddr); end
    step();
  endtask

  task automatic test_reset_in_busy();
    int pulses;
    drive_issue(32'h00000077, 32'h0);
    set_req(1'b1, 32'h400, 32'h4444, 4'hF, 1'b1);
    step();
    mem_cen = 1'b0; mem_gnt = 1'b0;
    step();
    vtx_reset = 1'b1;
    cpr_wen = 1'b1; cpr_waddr = 4'd4; cpr_wdata = 32'h44;
    set_rsp(3'd1, 32'h1, 5'd1, 1'b1);
    step();
    vtx_reset = 1'b0; cpr_wen = 1'b0; clr_rsp();
    n_cmp++; if (cop_insn_ready !== 1'b1 || vtx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_state: ready %0b valid %0b exp 1 0", cop_insn_ready, vtx_valid); end
    n_cmp++; if (vtx_mem_cen !== 4'h0 || vtx_cprs_pre !== 512'h0) begin n_fail++; $display("FAIL rst_busy_clear: cen %b exp 0, pre cleared", vtx_mem_cen); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (vtx_valid === 1'b1) pulses++;
      step();
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_busy_no_pulse: got %0d exp 0", pulses); end
    drive_issue(32'h00000088, 32'h0);
    set_rsp(3'd0, 32'h0, 5'd0, 1'b0);
    step();
    clr_rsp();
    n_cmp++; if (vtx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next_valid: got %0b exp 1", vtx_valid); end
    n_cmp++; if (vtx_mem_cen !== 4'h0 || vtx_mem_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_next_mem: cen %b ovf %0b exp 0 0", vtx_mem_cen, vtx_mem_ovf); end
    n_cmp++; if (vtx_cprs_pre[4*32 +: 32] !== 32'h0 || vtx_cprs_pre[3*32 +: 32] !== 32'h0) begin n_fail++; $display("FAIL rst_shadow: c4 %h c3 %h exp 0 0", vtx_cprs_pre[4*32 +: 32], vtx_cprs_pre[3*32 +: 32]); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_cpr_write();
    test_two_loads();
    test_overflow();
    test_late_request();
    test_reset_in_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
